// File: rtl/fxp_pkg.sv
// Shared sign-magnitude fixed-point definitions for the training datapath.
package fxp_pkg;

    localparam int FXP_Q = 15;
    localparam int FXP_N = 32;

    typedef logic [FXP_N-1:0] sm_word_t;

    localparam sm_word_t MAX_POS = 32'h7FFF_FFFF;
    localparam sm_word_t MAX_NEG = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } bp_state_t;

endpackage

// File: rtl/sm_sat_mac.sv
// Combinational sign-magnitude saturating multiply-accumulate: result = sat_add(addend, sat_mul(a, b)).
module sm_sat_mac
    import fxp_pkg::*;
#(
    parameter int Q = FXP_Q,
    parameter int N = FXP_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] addend,
    output logic [N-1:0] result,
    output logic         ovf
);
    localparam int M = N - 1;

    // Returns {ovf, word}; keeps the full 2M-bit magnitude product before the Q shift.
    function automatic logic [N:0] sat_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*M-1:0] full;
        logic [M-1:0]   mag;
        logic           o;
        full = {{M{1'b0}}, x[M-1:0]} * {{M{1'b0}}, y[M-1:0]};
        o    = |full[2*M-1:M+Q];
        mag  = o ? '1 : full[M-1+Q:Q];
        return {o, (x[M] ^ y[M]) & (mag != '0), mag};
    endfunction

    function automatic logic [N:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [M:0]   sum;
        logic [M-1:0] mag;
        logic         sgn;
        logic         o;
        sum = '0;
        o   = 1'b0;
        if (x[M] == y[M]) begin
            sum = {1'b0, x[M-1:0]} + {1'b0, y[M-1:0]};
            o   = sum[M];
            mag = o ? '1 : sum[M-1:0];
            sgn = x[M];
        end else if (x[M-1:0] >= y[M-1:0]) begin
            mag = x[M-1:0] - y[M-1:0];
            sgn = x[M];
        end else begin
            mag = y[M-1:0] - x[M-1:0];
            sgn = y[M];
        end
        return {o, sgn & (mag != '0), mag};
    endfunction

    logic [N:0] mul_r;
    logic [N:0] add_r;

    always_comb begin
        mul_r  = sat_mul(a, b);
        add_r  = sat_add(addend, mul_r[N-1:0]);
        result = add_r[N-1:0];
        ovf    = mul_r[N] | add_r[N];
    end

endmodule

// File: rtl/backprop_delta_accum.sv
// Backward-pass transpose dot product accumulator, one (weight, delta) term per cycle.
// Optional derivative scaling of the final sum is enabled with `define BP_DERIV_EN.
module backprop_delta_accum
    import fxp_pkg::*;
#(
    parameter int Q     = FXP_Q,
    parameter int N     = FXP_N,
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     weight,
    input  logic [N-1:0]     delta,
    input  logic [N-1:0]     deriv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     delta_in,
    output logic             ovf,
    output logic             busy
);
    bp_state_t        state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;

    logic [N-1:0] mac_a, mac_b, mac_addend, mac_res;
    logic         mac_ovf;
    logic         accept;
    logic         last_term;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign delta_in  = acc_q;
    assign ovf       = ovf_q;
    assign accept    = in_ready && in_valid;
    assign last_term = ((count_q + 1'b1) == len_q);

    // The single MAC doubles as the derivative scaler in SCALE by zeroing the addend.
    always_comb begin
        if (state_q == SCALE) begin
            mac_a      = acc_q;
            mac_b      = deriv;
            mac_addend = '0;
        end else begin
            mac_a      = weight;
            mac_b      = delta;
            mac_addend = acc_q;
        end
    end

    sm_sat_mac #(.Q(Q), .N(N)) u_mac (
        .a      (mac_a),
        .b      (mac_b),
        .addend (mac_addend),
        .result (mac_res),
        .ovf    (mac_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        len_d   = len_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = mac_res;
                    ovf_d   = ovf_q | mac_ovf;
                    count_d = count_q + 1'b1;
                    if (last_term) begin
`ifdef BP_DERIV_EN
                        state_d = SCALE;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef BP_DERIV_EN
            SCALE: begin
                acc_d   = mac_res;
                ovf_d   = ovf_q | mac_ovf;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/backprop_delta_accum.md
# backprop_delta_accum

Sequential backward-pass counterpart of the forward partial dot product. Accumulates the transpose dot product delta_in[j] = sum over k of W[k][j] * delta_out[k] in sign-magnitude Q16.15 fixed point. It consumes one (weight, delta) term per cycle over a valid/ready stream and returns one saturated result per job. It sits between the layer's weight/delta memories and the weight-update stage of the training datapath.

## Interface
Parameters:
- Q, 15, fraction bits.
- N, 32, word width (bit N-1 is sign, bits N-2:0 are magnitude).
- LEN_W, 10, width of the job term count.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  LEN_W  number of terms in the job; sampled with start.
- in_valid  in  1  weight/delta term valid.
- in_ready  out  1  block accepts a term this cycle.
- weight  in  N  W[k][j], sign-magnitude Q.
- delta  in  N  delta_out[k], sign-magnitude Q.
- deriv  in  N  activation derivative f'(z_j); used only with BP_DERIV_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- delta_in  out  N  result.
- ovf  out  1  saturation occurred anywhere in the job (sticky per job).
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: in_ready=0, waits for start.
  - ACCUM: in_ready=1.
  - SCALE: only present with BP_DERIV_EN.
  - DONE: out_valid=1.
- IDLE, start=1: latch len, clear the accumulator and ovf, zero the term counter. Go to DONE if len=0 (result 0). Otherwise go to ACCUM.
- ACCUM: a term is accepted on in_valid && in_ready.
  - On each accept: acc <= sat_add(acc, sat_mul(weight, delta)) and count++.
  - On the accept where count reaches len: go to SCALE if BP_DERIV_EN, else go to DONE.
  - in_valid=0 stalls; no state changes.
- SCALE: acc <= sat_mul(acc, deriv) for one cycle, then go to DONE.
- DONE: hold delta_in and ovf stable. On out_ready, return to IDLE the next cycle.
- start outside IDLE is ignored.
- sat_mul:
  - Sign is the XOR of the input signs.
  - Magnitude is (|a| * |b|) >> Q, taking the full 2(N-1)-bit product.
  - If any product bit above bit N-2+Q is set, the magnitude saturates to all ones and ovf is set.
- sat_add:
  - Equal signs: add magnitudes. On carry out of bit N-2, saturate the magnitude to all ones and set ovf.
  - Unequal signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
- Zero results are always positive (negative zero normalized to 0x00000000).
- Saturation does not stop accumulation. Later terms may bring acc back down; ovf stays set.

## Timing
- Reset values:
  - state IDLE.
  - in_ready=0, out_valid=0, busy=0, ovf=0.
  - delta_in=0, acc=0, count=0.
- Reset mid-job (any state) aborts the job. Results are never partially delivered.
- Throughput is one term per cycle with no bubbles while in_valid=1.
- Latency from the last accepted term to out_valid:
  - 1 cycle without BP_DERIV_EN.
  - 2 cycles with BP_DERIV_EN.
- start-to-first-accept: in_ready rises the cycle after start.
- len=0: out_valid is high the cycle after start, with delta_in=0 and ovf=0.
- out_valid and out_ready high together completes the handshake. The block is in IDLE the next cycle and can take start the cycle after that.
- deriv is sampled in the SCALE cycle only.

## Configuration
- BP_DERIV_EN defined:
  - SCALE state exists.
  - Result is sat_mul(sum, deriv).
  - The deriv port is live.
- BP_DERIV_EN undefined:
  - No SCALE state.
  - Result is the raw sum.
  - deriv is ignored (port kept for pin compatibility).

## Structure
- Shared package (fxp_pkg) holds:
  - the Q and N defaults;
  - the sign-magnitude word typedef;
  - the saturation constants MAX_POS=0x7FFFFFFF and MAX_NEG=0xFFFFFFFF;
  - the state enum {IDLE, ACCUM, SCALE, DONE}.
- One sub-module is natural: sm_sat_mac, the combinational sat_mul + sat_add with an ovf output.
  - It is instanced once.
  - In SCALE it is reused with the addend forced to 0, so no second multiplier is needed.

## Test plan
- len=3; (1.0, 0.5), (0.5, -1.0), (2.0, 0.25) = (0x00008000, 0x00004000), (0x00004000, 0x80008000), (0x00010000, 0x00002000) -> delta_in=0x00004000 (0.5), ovf=0, out_valid one cycle after the third accept.
- len=2; (0x7FFF8000, 0x00010000) twice -> product saturates, delta_in=0x7FFFFFFF, ovf=1.
- len=0 start -> out_valid the next cycle, delta_in=0, ovf=0; then hold out_ready=0 for 5 cycles -> output held stable.
- len=4 with in_valid toggling 1,0,1,0,… and (1.0, 1.0) terms -> delta_in=0x00020000 after 4 accepts, no extra or lost terms.
- rst asserted after 2 of 4 terms -> all outputs 0 next cycle; a new len=1 job with (−1.0, 1.0) then returns 0x80008000.
- BP_DERIV_EN: len=1, (1.0, 1.0), deriv=0x00004000 -> delta_in=0x00004000, out_valid 2 cycles after the accept; terms (1.0, 1.0) and (1.0, −1.0) -> 0x00000000, not 0x80000000.
